// File: rtl/text_scanner_pkg.sv
// rtl/text_scanner_pkg.sv - shared VGA timing, Apple window and fetch FSM definitions
package text_scanner_pkg;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;

    // 640x480@60 vertical timing, in lines
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;

    // 280x192 Apple frame doubled to 560x384 and centred
    localparam logic [9:0] WIN_X0 = 10'd40;
    localparam logic [9:0] WIN_Y0 = 10'd48;
    localparam logic [9:0] WIN_X1 = WIN_X0 + 10'd560;
    localparam logic [9:0] WIN_Y1 = WIN_Y0 + 10'd384;

    localparam logic [9:0] CELL_W    = 10'd14;
    localparam logic [5:0] CELL_COLS = 6'd40;

    localparam logic [7:0] BLANK_CHAR = 8'hA0;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DATA
    } fetch_state_t;

    // Apple II text rows are interleaved: rows 0..7 step by 128 bytes,
    // each group of eight rows is offset by another 40 bytes.
    function automatic logic [15:0] row_offset(input logic [4:0] row);
        return {6'b0, row[2:0], 7'b0} + 16'(row[4:3]) * 16'd40;
    endfunction

endpackage

// File: rtl/text_scanner_vga_sync_counter.sv
// rtl/text_scanner_vga_sync_counter.sv - 800x525 raster counters with raw syncs and blank
//
// Ports:
//   clkVGA, rst_n          pixel clock, asynchronous active-low reset
//   hCount, vCount         current raster position
//   hNext, vNext           position the counters take at the next edge
//   hsync_raw_n, vsync_raw_n, blank_raw   undelayed timing decoded from the counters
module vga_sync_counter
    import text_scanner_pkg::*;
(
    input  logic       clkVGA,
    input  logic       rst_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic [9:0] hNext,
    output logic [9:0] vNext,
    output logic       hsync_raw_n,
    output logic       vsync_raw_n,
    output logic       blank_raw
);

    always_comb begin
        hNext = hCount + 10'd1;
        vNext = vCount;
        if (hCount == H_TOTAL - 10'd1) begin
            hNext = 10'd0;
            vNext = (vCount == V_TOTAL - 10'd1) ? 10'd0 : vCount + 10'd1;
        end
    end

    always_ff @(posedge clkVGA or negedge rst_n) begin
        if (!rst_n) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
        end else begin
            hCount <= hNext;
            vCount <= vNext;
        end
    end

    assign hsync_raw_n = !((hCount >= H_SYNC_START) && (hCount < H_SYNC_START + H_SYNC));
    assign vsync_raw_n = !((vCount >= V_SYNC_START) && (vCount < V_SYNC_START + V_SYNC));
    assign blank_raw   = (hCount >= H_VISIBLE) || (vCount >= V_VISIBLE);

endmodule

// File: rtl/text_scanner.sv
// rtl/text_scanner.sv - VGA timing plus Apple II text page walker feeding the character generator
//
// Optional feature macro: TEXT_PAGE2_EN (adds the page2 input selecting PAGE2_BASE).
//
// Ports:
//   clkVGA, rst_n                 pixel clock, asynchronous active-low reset
//   page2                         page select, latched at the start of each frame (TEXT_PAGE2_EN only)
//   memAddr, memRd                video RAM request; memRd held until grant or deadline
//   memGrant, memData             arbiter grant; data valid the cycle after the grant
//   charApple, xPos, yPos, active registered cell code and Apple coordinates
//   hsync_n, vsync_n, blank       timing, delayed 1+PIPE_DELAY clocks behind the counters
//   fetchMiss                     one-cycle pulse when a fetch is not granted in time
module text_scanner
    import text_scanner_pkg::*;
#(
    parameter int          PIPE_DELAY = 1,
    parameter logic [15:0] PAGE1_BASE = 16'h0400,
    parameter logic [15:0] PAGE2_BASE = 16'h0800
) (
    input  logic        clkVGA,
    input  logic        rst_n,
`ifdef TEXT_PAGE2_EN
    input  logic        page2,
`endif
    output logic [15:0] memAddr,
    output logic        memRd,
    input  logic        memGrant,
    input  logic [7:0]  memData,
    output logic [7:0]  charApple,
    output logic [9:0]  xPos,
    output logic [9:0]  yPos,
    output logic        active,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        fetchMiss
);

    localparam int SYNC_LAG = 1 + PIPE_DELAY;

    logic [9:0] hCount, vCount, hNext, vNext;
    logic       hsync_raw_n, vsync_raw_n, blank_raw;

    vga_sync_counter u_counter (
        .clkVGA      (clkVGA),
        .rst_n       (rst_n),
        .hCount      (hCount),
        .vCount      (vCount),
        .hNext       (hNext),
        .vNext       (vNext),
        .hsync_raw_n (hsync_raw_n),
        .vsync_raw_n (vsync_raw_n),
        .blank_raw   (blank_raw)
    );

    // Page selection only takes effect at frame start so a frame never tears.
    logic page2_in;
    logic page2_q;
`ifdef TEXT_PAGE2_EN
    assign page2_in = page2;
`else
    assign page2_in = 1'b0;
`endif

    logic [15:0] base_addr;
    assign base_addr = page2_q ? PAGE2_BASE : PAGE1_BASE;

    fetch_state_t fstate;
    logic [1:0]   wait_cnt;
    logic [5:0]   fetch_col;     // next column to fetch on this line
    logic [7:0]   char_buf;

    logic       line_active;
    logic [9:0] cell_base;
    logic       fetch_go;
    logic       load_cell;
    logic       next_in_win;
    logic [4:0] apple_row;
    logic [15:0] fetch_addr;

    assign line_active = (vCount >= WIN_Y0) && (vCount < WIN_Y1);
    assign cell_base   = {fetch_col, 4'b0} - {3'b0, fetch_col, 1'b0};

    // Request for column c goes out in cycle 14c+36, so the FSM leaves idle one edge earlier.
    assign fetch_go  = line_active && (fetch_col < CELL_COLS) && (hCount == cell_base + 10'd35);
    // fetch_col is already c+1 by the time column c is presented at 14c+39.
    assign load_cell = line_active && (fetch_col != 6'd0) && (hCount == cell_base + 10'd25);

    assign next_in_win = (hNext >= WIN_X0) && (hNext < WIN_X1) &&
                         (vNext >= WIN_Y0) && (vNext < WIN_Y1);

    assign apple_row  = 5'((vCount - WIN_Y0) >> 4);
    assign fetch_addr = base_addr + row_offset(apple_row) + {10'b0, fetch_col};

    // The deadline cycle itself is still grantable, so the miss is decided from
    // that cycle's grant rather than a registered copy of it.
    assign fetchMiss = (fstate == F_REQ) && (wait_cnt == 2'd2) && !memGrant;

    always_ff @(posedge clkVGA or negedge rst_n) begin
        if (!rst_n) begin
            fstate    <= F_IDLE;
            wait_cnt  <= 2'd0;
            fetch_col <= 6'd0;
            char_buf  <= BLANK_CHAR;
            memRd     <= 1'b0;
            memAddr   <= 16'd0;
            page2_q   <= 1'b0;
            charApple <= BLANK_CHAR;
            xPos      <= 10'd0;
            yPos      <= 10'd0;
            active    <= 1'b0;
        end else begin
            if ((hCount == 10'd0) && (vCount == 10'd0)) begin
                page2_q <= page2_in;
            end

            case (fstate)
                F_IDLE: begin
                    if (fetch_go) begin
                        fstate    <= F_REQ;
                        memRd     <= 1'b1;
                        memAddr   <= fetch_addr;
                        wait_cnt  <= 2'd0;
                        fetch_col <= fetch_col + 6'd1;
                    end
                end
                F_REQ: begin
                    if (memGrant) begin
                        fstate <= F_DATA;
                        memRd  <= 1'b0;
                    end else if (wait_cnt == 2'd2) begin
                        fstate   <= F_IDLE;
                        memRd    <= 1'b0;
                        char_buf <= BLANK_CHAR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                F_DATA: begin
                    char_buf <= memData;
                    fstate   <= F_IDLE;
                end
                default: begin
                    fstate <= F_IDLE;
                    memRd  <= 1'b0;
                end
            endcase

            if (hCount == H_TOTAL - 10'd1) begin
                fetch_col <= 6'd0;
            end

            // Registered outputs describe the position the counters are about to take.
            active <= next_in_win;
            xPos   <= next_in_win ? (hNext - WIN_X0) >> 1 : 10'd0;
            yPos   <= next_in_win ? (vNext - WIN_Y0) >> 1 : 10'd0;
            if (!next_in_win) begin
                charApple <= BLANK_CHAR;
            end else if (load_cell) begin
                // A grant in the deadline cycle lands its data exactly at presentation time.
                charApple <= (fstate == F_DATA) ? memData : char_buf;
            end
        end
    end

    // Sync/blank delay lines; reset fills them with the idle levels.
    logic [SYNC_LAG-1:0] hs_pipe, vs_pipe, bl_pipe;

    always_ff @(posedge clkVGA or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
            bl_pipe <= '1;
        end else begin
            hs_pipe[0] <= hsync_raw_n;
            vs_pipe[0] <= vsync_raw_n;
            bl_pipe[0] <= blank_raw;
            for (int i = 1; i < SYNC_LAG; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                bl_pipe[i] <= bl_pipe[i-1];
            end
        end
    end

    assign hsync_n = hs_pipe[SYNC_LAG-1];
    assign vsync_n = vs_pipe[SYNC_LAG-1];
    assign blank   = bl_pipe[SYNC_LAG-1];

endmodule

// File: tb/tb_text_scanner.sv
// tb/tb_text_scanner.sv - self-checking bench for text_scanner
module tb_text_scanner;

    localparam int LAG = 2;
`ifdef TEXT_PAGE2_EN
    localparam logic [15:0] LIT_BASE = 16'h0800;
`else
    localparam logic [15:0] LIT_BASE = 16'h0400;
`endif

    logic        clkVGA = 1'b0;
    logic        rst_n;
    logic        page2;
    logic [15:0] memAddr;
    logic        memRd;
    logic        memGrant;
    logic [7:0]  memData;
    logic [7:0]  charApple;
    logic [9:0]  xPos, yPos;
    logic        active, hsync_n, vsync_n, blank, fetchMiss;

    int checks = 0;
    int failures = 0;

    always #20 clkVGA = ~clkVGA;

    text_scanner #(.PIPE_DELAY(1)) dut (
        .clkVGA    (clkVGA),
        .rst_n     (rst_n),
`ifdef TEXT_PAGE2_EN
        .page2     (page2),
`endif
        .memAddr   (memAddr),
        .memRd     (memRd),
        .memGrant  (memGrant),
        .memData   (memData),
        .charApple (charApple),
        .xPos      (xPos),
        .yPos      (yPos),
        .active    (active),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .blank     (blank),
        .fetchMiss (fetchMiss)
    );

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
        end
    endtask

    // Grant latency per cell: 0..2 clocks after the request, 3 means never granted.
    function automatic int gd_of(input int v, input int c);
        if (v == 48) return 0;
        if (v == 50 && c == 5) return 3;
        return (v + 2 * c) % 4;
    endfunction

    function automatic logic [7:0] data_pat(input int v, input int h);
        if (v == 48) return 8'hC1;
        return 8'(v * 3 + h * 7) ^ 8'h5A;
    endfunction

    function automatic logic hs_raw(input int h);
        return !(h >= 656 && h < 752);
    endfunction

    function automatic logic vs_raw(input int v);
        return !(v >= 490 && v < 492);
    endfunction

    function automatic logic bl_raw(input int h, input int v);
        return (h >= 640) || (v >= 480);
    endfunction

    function automatic logic in_fetch_zone(input int h, input int v);
        return (v >= 48) && (v < 432) && (h >= 36) && ((h - 36) / 14 < 40) && ((h - 36) % 14 <= 2);
    endfunction

    task automatic drive(input int h, input int v);
        memData  = data_pat(v, h);
        memGrant = 1'b1;
        if (in_fetch_zone(h, v))
            memGrant = ((h - 36) % 14) >= gd_of(v, (h - 36) / 14);
    endtask

    task automatic compare(input int t, input int h, input int v);
        logic       win, e_rd, e_miss;
        logic [7:0] e_char;
        logic [15:0] e_addr;
        int c, off, g, row, tp;
        win = (h >= 40) && (h < 600) && (v >= 48) && (v < 432);
        tp  = t - LAG;
        if (t >= LAG) begin
            chk("hsync_n", t, hsync_n, hs_raw(tp % 800));
            chk("vsync_n", t, vsync_n, vs_raw((tp / 800) % 525));
            chk("blank", t, blank, bl_raw(tp % 800, (tp / 800) % 525));
        end else begin
            chk("hsync_n", t, hsync_n, 1);
            chk("vsync_n", t, vsync_n, 1);
            chk("blank", t, blank, 1);
        end
        chk("active", t, active, win);
        chk("xPos", t, xPos, win ? (h - 40) / 2 : 0);
        chk("yPos", t, yPos, win ? (v - 48) / 2 : 0);
        e_char = 8'hA0;
        if (win) begin
            c = (h - 40) / 14;
            g = gd_of(v, c);
            if (g != 3) e_char = data_pat(v, 36 + 14 * c + g + 1);
        end
        chk("charApple", t, charApple, e_char);
        e_rd = 1'b0;
        e_miss = 1'b0;
        e_addr = 16'h0;
        if (in_fetch_zone(h, v)) begin
            c   = (h - 36) / 14;
            off = (h - 36) % 14;
            g   = gd_of(v, c);
            e_rd   = (g == 3) ? 1'b1 : (off <= g);
            e_miss = (g == 3) && (off == 2);
            row    = (v - 48) / 16;
            e_addr = LIT_BASE + 16'((row % 8) * 128 + (row / 8) * 40 + c);
        end
        chk("memRd", t, memRd, e_rd);
        chk("fetchMiss", t, fetchMiss, e_miss);
        if (e_rd) chk("memAddr", t, memAddr, e_addr);
    endtask

    task automatic literal_checks(input int phase, input int t, input int h, input int v);
        if (t == 657) chk("lit_hs_pre", t, hsync_n, 1);
        if (t == 658) chk("lit_hs_low", t, hsync_n, 0);
        if (t == 753) chk("lit_hs_end", t, hsync_n, 0);
        if (t == 754) chk("lit_hs_up", t, hsync_n, 1);
        if (t == 641) chk("lit_bl_vis", t, blank, 0);
        if (t == 642) chk("lit_bl_on", t, blank, 1);
        if (phase == 0) begin
            if (v == 48 && h == 35) chk("lit_rd_pre", t, memRd, 0);
            if (v == 48 && h == 36) begin
                chk("lit_rd_c0", t, memRd, 1);
                chk("lit_addr_c0", t, memAddr, LIT_BASE);
            end
            if (v == 48 && h == 582) chk("lit_addr_c39", t, memAddr, LIT_BASE + 16'h0027);
            if (v == 64 && h == 36) chk("lit_addr_row1", t, memAddr, LIT_BASE + 16'h0080);
            if (v == 48 && h == 40) begin
                chk("lit_char_40", t, charApple, 8'hC1);
                chk("lit_x_40", t, xPos, 0);
            end
            if (v == 48 && h == 53) begin
                chk("lit_char_53", t, charApple, 8'hC1);
                chk("lit_x_53", t, xPos, 6);
            end
            if (v == 50 && h == 40) chk("lit_y_50", t, yPos, 1);
            if (v == 50 && h == 108) chk("lit_miss", t, fetchMiss, 1);
            if (v == 50 && (h == 110 || h == 123)) chk("lit_miss_char", t, charApple, 8'hA0);
        end
    endtask

    task automatic run_cycles(input int n, input int phase);
        for (int t = 0; t < n; t++) begin
            int h, v;
            h = t % 800;
            v = (t / 800) % 525;
            drive(h, v);
            #1;
            compare(t, h, v);
            literal_checks(phase, t, h, v);
            @(negedge clkVGA);
        end
    endtask

    task automatic check_reset_values(input int t);
        chk("rst_memRd", t, memRd, 0);
        chk("rst_memAddr", t, memAddr, 16'h0);
        chk("rst_char", t, charApple, 8'hA0);
        chk("rst_xPos", t, xPos, 0);
        chk("rst_yPos", t, yPos, 0);
        chk("rst_active", t, active, 0);
        chk("rst_miss", t, fetchMiss, 0);
        chk("rst_hsync", t, hsync_n, 1);
        chk("rst_vsync", t, vsync_n, 1);
        chk("rst_blank", t, blank, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        page2    = 1'b1;
        memGrant = 1'b1;
        memData  = 8'h00;
        repeat (3) @(negedge clkVGA);
        check_reset_values(-1);
        rst_n = 1'b1;
        run_cycles(64 * 800 + 300, 0);
        rst_n = 1'b0;
        #1;
        check_reset_values(-2);
        repeat (2) @(negedge clkVGA);
        rst_n = 1'b1;
        run_cycles(1700, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
